nibble_stream_ctrl: RTL
=======================

// Module: nibble_stream_ctrl
// PURPOSE
//   Sequencer for the 128-bit nibble-select datapath (giantMux). Accepts one
//   128-bit block over a valid/ready handshake, registers it, then steps the
//   5-bit mux index so the block streams out one 4-bit nibble per accepted beat.
//   Sits between the block source (key/keystream/plaintext buffer) and any
//   nibble-wide consumer in the encrypt/decrypt path.
// PARAMETERS
//   MSB_FIRST  0  0: emit nibble 0 (bits 3:0) first, index counts up;
//                 1: emit nibble 31 (bits 127:124) first, index counts down
// PORTS
//   clock       in   1    single clock, all state on posedge
//   reset       in   1    asynchronous, active-high
//   in_valid    in   1    source offers in_block/in_count
//   in_ready    out  1    controller can accept a block
//   in_block    in   128  block to serialise
//   in_count    in   6    nibbles to emit, 1..32; 0 or >32 means 32
//   flush       in   1    synchronous abort of the current block
//   out_nibble  out  4    current nibble = in_block_q[4*mux_index +: 4]
//   out_valid   out  1    out_nibble is valid
//   out_ready   in   1    consumer takes the nibble this cycle
//   out_last    out  1    current beat is the final nibble of the block
//   mux_index   out  5    index driven into the mux select
//   busy        out  1    block in flight (state == STREAM)
// BEHAVIOUR
//   - Reset (async): state=IDLE, block_q=0, count_q=0, beat_q=0,
//     mux_index=0 (31 if MSB_FIRST), out_valid=0, out_last=0, busy=0.
//     in_ready=0 while reset is asserted.
//   - FSM: IDLE, STREAM.
//     IDLE: in_ready=1, out_valid=0. in_valid&in_ready at edge N ->
//       capture block_q, count_q (clamped), beat_q=0, mux_index=start index;
//       STREAM from cycle N+1 (accept-to-first-nibble latency: 1 cycle).
//     STREAM: in_ready=0, out_valid=1, busy=1; out_nibble is combinational
//       from block_q and mux_index (same cycle, no extra register).
//       out_last = (beat_q == count_q-1).
//       out_valid&out_ready: if out_last -> IDLE; else beat_q+1 and
//       mux_index +1 (or -1 if MSB_FIRST).
//       out_ready low: out_nibble, mux_index, out_last held unchanged.
//   - Index never wraps: count clamp guarantees the final index is 31
//     (MSB_FIRST=0) or 0 (MSB_FIRST=1) at most.
//   - Between blocks: one bubble cycle (IDLE) after the last beat; in_ready
//     is never asserted while a block is streaming.
//   - flush in STREAM: -> IDLE next edge, no out_last, remaining nibbles
//     dropped. flush in IDLE: ignored; flush wins over a same-cycle accept
//     (in_ready forced 0 while flush=1).
//   - flush and last-beat handshake in the same cycle: the beat counts as
//     delivered; next state IDLE either way.
//   - Reset mid-stream: immediate return to reset values; block discarded.
// STRUCTURE
//   - Shared package: NIBBLES=32, IDX_W=5, CNT_W=6, BLOCK_W=128, state enum
//     {IDLE, STREAM}.
//   - One sub-module: giantMux instance (in=block_q, index=mux_index,
//     out=out_nibble); decoder/tri-state select stays inside it.
//   - This block contains only the FSM, block/count registers, beat counter
//     and index stepper.
// TESTING
//   1. block=128'hFEDCBA98_76543210_FEDCBA98_76543210, count=0, MSB_FIRST=0,
//      out_ready=1 -> 32 beats 0,1,..,F,0,..,F; out_last only on beat 32;
//      in_ready=1 one cycle later.
//   2. Same block, MSB_FIRST=1, count=3 -> nibbles F,E,D with indices
//      31,30,29; out_last on D; then IDLE.
//   3. Backpressure: drop out_ready for 3 cycles at beat 5 (index 5,
//      nibble 5) -> mux_index=5 and out_nibble=5 held for all 3 cycles;
//      stream resumes with 6; no beats lost or duplicated.
//   4. flush at beat 10 -> IDLE next edge, out_valid=0, out_last never seen;
//      next block accepted normally starting at index 0.
//   5. in_valid held high with two blocks (count=2 each) -> beats A0,A1,
//      bubble, B0,B1; in_ready low throughout streaming.
//   6. Assert reset at beat 7 -> outputs at reset values immediately
//      (async); after release, in_ready=1 and first accept restarts at 0.

Source files
------------

// File: rtl/nibble_stream_ctrl_pkg.sv
// Shared constants, state encoding and count clamp for the nibble stream controller.
package nibble_stream_ctrl_pkg;

    localparam int NIBBLES = 32;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 6;
    localparam int BLOCK_W = 128;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // A request of 0 or anything above 32 nibbles means "the whole block".
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
        if ((cnt == '0) || (cnt > CNT_W'(NIBBLES))) begin
            return CNT_W'(NIBBLES);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/nibble_stream_ctrl_giant_mux.sv
// giantMux: selects one 4-bit nibble out of a 128-bit block by a 5-bit index.
// The one-hot decoder and its gated select lines live here; the tri-state bus
// of the original datapath is realised as an AND-OR tree so it maps to fabric.
module nibble_stream_ctrl_giant_mux
    import nibble_stream_ctrl_pkg::*;
(
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [IDX_W-1:0]   index,
    output logic [3:0]         out_nibble
);

    logic [NIBBLES-1:0] sel;
    logic [3:0]         masked [NIBBLES];

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_lane
        assign sel[gi]    = (index == IDX_W'(gi));
        assign masked[gi] = in_block[4*gi +: 4] & {4{sel[gi]}};
    end

    // Only the selected lane is non-zero, so OR-ing all lanes yields that nibble.
    always_comb begin
        out_nibble = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            out_nibble = out_nibble | masked[i];
        end
    end

endmodule

// File: rtl/nibble_stream_ctrl.sv
// Sequencer that accepts one 128-bit block and streams it out nibble by nibble,
// stepping the giantMux index once per accepted output beat.
module nibble_stream_ctrl
    import nibble_stream_ctrl_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [CNT_W-1:0]   in_count,
    input  logic               flush,
    output logic [3:0]         out_nibble,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [IDX_W-1:0]   mux_index,
    output logic               busy
);

    localparam logic [IDX_W-1:0] START_IDX = MSB_FIRST ? IDX_W'(NIBBLES - 1) : '0;

    state_t             state_reg,  state_next;
    logic [BLOCK_W-1:0] block_reg,  block_next;
    logic [CNT_W-1:0]   count_reg,  count_next;
    logic [CNT_W-1:0]   beat_reg,   beat_next;
    logic [IDX_W-1:0]   idx_reg,    idx_next;
    logic               last_beat;
    logic               idle_ready;

    // Final beat of the block; count_reg is always 1..32 while streaming.
    assign last_beat = (beat_reg == (count_reg - CNT_W'(1)));

    // Next-state, datapath capture/step and handshake outputs.
    always_comb begin
        state_next = state_reg;
        block_next = block_reg;
        count_next = count_reg;
        beat_next  = beat_reg;
        idx_next   = idx_reg;
        idle_ready = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                // flush blocks a same-cycle accept.
                idle_ready = !flush;
                if (in_valid && !flush) begin
                    block_next = in_block;
                    count_next = clamp_count(in_count);
                    beat_next  = '0;
                    idx_next   = START_IDX;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = last_beat;
                if (flush) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                    end else begin
                        beat_next = beat_reg + CNT_W'(1);
                        idx_next  = MSB_FIRST ? (idx_reg - IDX_W'(1)) : (idx_reg + IDX_W'(1));
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // in_ready is also masked by reset so nothing is offered during reset.
    assign in_ready  = idle_ready && !reset;
    assign mux_index = idx_reg;

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            block_reg <= '0;
            count_reg <= '0;
            beat_reg  <= '0;
            idx_reg   <= START_IDX;
        end else begin
            state_reg <= state_next;
            block_reg <= block_next;
            count_reg <= count_next;
            beat_reg  <= beat_next;
            idx_reg   <= idx_next;
        end
    end

    nibble_stream_ctrl_giant_mux u_giant_mux (
        .in_block   (block_reg),
        .index      (idx_reg),
        .out_nibble (out_nibble)
    );

endmodule
